// File: rtl/mem_arbiter_if.sv
// Shared memory-port bundle between the D-cache, I-cache, the arbiter and the memory model.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writeData;
    logic [DATA_W-1:0] d_readData;
    logic              d_busywait;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readData;
    logic              i_busywait;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic [DATA_W-1:0] mem_readData;
    logic              mem_busywait;

    logic [1:0]        grant;

    modport slave (
        input  d_read, d_write, d_address, d_writeData,
        output d_readData, d_busywait,
        input  i_read, i_address,
        output i_readData, i_busywait,
        output mem_read, mem_write, mem_address, mem_writeData,
        input  mem_readData, mem_busywait,
        output grant
    );

    modport master (
        output d_read, d_write, d_address, d_writeData,
        input  d_readData, d_busywait,
        output i_read, i_address,
        input  i_readData, i_busywait,
        input  mem_read, mem_write, mem_address, mem_writeData,
        output mem_readData, mem_busywait,
        input  grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between the D-cache and I-cache miss paths.
// Grant is held for the owner's whole transaction and released when its request drops.
module mem_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter bit RR_MODE = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        D_GRANT = 2'b01,
        I_GRANT = 2'b10
    } state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_t;

    state_t            state;
    state_t            next_state;
    owner_t            last_owner;

    logic              d_req;
    logic              i_req;

    logic              mux_read;
    logic              mux_write;
    logic [ADDR_W-1:0] mux_address;
    logic [DATA_W-1:0] mux_writeData;

    assign d_req = bus.d_read | bus.d_write;
    assign i_req = bus.i_read;

    // Tie-break only matters from IDLE; hand-offs from a releasing owner go straight across.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (d_req && i_req) begin
                    if (RR_MODE && (last_owner == OWN_D))
                        next_state = I_GRANT;
                    else
                        next_state = D_GRANT;
                end else if (d_req) begin
                    next_state = D_GRANT;
                end else if (i_req) begin
                    next_state = I_GRANT;
                end
            end
            D_GRANT: begin
                if (!d_req)
                    next_state = i_req ? I_GRANT : IDLE;
            end
            I_GRANT: begin
                if (!i_req)
                    next_state = d_req ? D_GRANT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWN_I;
            bus.grant  <= '0;
        end else begin
            state     <= next_state;
            bus.grant <= next_state;
            if ((state == D_GRANT) && !d_req)
                last_owner <= OWN_D;
            else if ((state == I_GRANT) && !i_req)
                last_owner <= OWN_I;
        end
    end

    // A simultaneous read and write from the D-cache is a write-back; the read is masked.
    always_comb begin
        mux_read      = 1'b0;
        mux_write     = 1'b0;
        mux_address   = '0;
        mux_writeData = '0;
        unique case (state)
            D_GRANT: begin
                mux_read      = bus.d_read & ~bus.d_write;
                mux_write     = bus.d_write;
                mux_address   = bus.d_address;
                mux_writeData = bus.d_writeData;
            end
            I_GRANT: begin
                mux_read      = bus.i_read;
                mux_address   = bus.i_address;
            end
            default: ;
        endcase
    end

    assign bus.mem_read      = mux_read;
    assign bus.mem_write     = mux_write;
    assign bus.mem_address   = mux_address;
    assign bus.mem_writeData = mux_writeData;

    assign bus.d_busywait = (state == D_GRANT) ? bus.mem_busywait : d_req;
    assign bus.i_busywait = (state == I_GRANT) ? bus.mem_busywait : i_req;

    assign bus.d_readData = bus.mem_readData;
    assign bus.i_readData = bus.mem_readData;

endmodule
